// File: rtl/ir_receiver.sv
// ir_receiver -- pulse-distance IR frame decoder.
//
// A frame is a sync burst + sync silence, then MESSAGE_LENGTH bits each made
// of a fixed burst followed by a short (0) or long (1) silence, then a stop
// pulse of any length. All durations are in clk_in cycles, each accepted
// within +/- MARGIN of its nominal value.
//
// Ports:
//   clk_in          single clock, everything on its rising edge
//   rst_in          asynchronous, active-high reset
//   signal_in       asynchronous demodulated IR line (1 = burst, 0 = silence)
//   data_out        last correctly received payload (first bit on air = MSB)
//   data_valid_out  one-cycle pulse when data_out is updated
//   error_out       one-cycle pulse when a frame is aborted
//   busy_out        high while a frame is being decoded
//   state_dbg       current FSM state encoding, for observation only
//
// Handshake: there is no back-pressure. data_valid_out is a single-cycle
// strobe qualifying data_out; a consumer must capture data_out in that cycle
// or rely on it being held until the next good frame.
module ir_receiver #(
  parameter int unsigned SBD            = 900_000,
  parameter int unsigned SSD            = 450_000,
  parameter int unsigned BBD            = 60_000,
  parameter int unsigned BSD0           = 60_000,
  parameter int unsigned BSD1           = 160_000,
  parameter int unsigned MARGIN         = 20_000,
  parameter int unsigned MESSAGE_LENGTH = 30
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      signal_in,
  output logic [MESSAGE_LENGTH-1:0] data_out,
  output logic                      data_valid_out,
  output logic                      error_out,
  output logic                      busy_out,
  output logic [2:0]                state_dbg
);

  typedef enum logic [2:0] {
    WAIT_LOW     = 3'd0,
    IDLE         = 3'd1,
    SYNC_BURST   = 3'd2,
    SYNC_SILENCE = 3'd3,
    BIT_BURST    = 3'd4,
    BIT_SILENCE  = 3'd5,
    STOP         = 3'd6
  } state_t;

  localparam int CW = $clog2(MESSAGE_LENGTH + 1);

  // Durations widened to 33 bits so nominal+MARGIN never wraps.
  localparam logic [32:0] SBD_W    = 33'(SBD);
  localparam logic [32:0] SSD_W    = 33'(SSD);
  localparam logic [32:0] BBD_W    = 33'(BBD);
  localparam logic [32:0] BSD0_W   = 33'(BSD0);
  localparam logic [32:0] BSD1_W   = 33'(BSD1);
  localparam logic [32:0] MARGIN_W = 33'(MARGIN);
  localparam logic [32:0] BSIL_MAX = ((BSD1_W > BSD0_W) ? BSD1_W : BSD0_W) + MARGIN_W;

  state_t              state;
  logic                sync_q1, sync_q2, line_prev;
  logic [31:0]         cnt;
  logic [32:0]         dur;
  logic [32:0]         limit;
  logic                rise, fall, line_edge;
  logic                decoding, timeout, abort;
  logic                bit_ok0, bit_ok1;
  logic [CW-1:0]       bit_cnt;
  logic [MESSAGE_LENGTH-1:0] shift_q, shift_next;

  function automatic logic in_win(input logic [32:0] d, input logic [32:0] nom);
    logic [32:0] lo;
    lo = (nom > MARGIN_W) ? (nom - MARGIN_W) : '0;
    return (d >= lo) && (d <= (nom + MARGIN_W));
  endfunction

  // Synchronizer and edge register reset high so a line that is already
  // bursting when reset is released does not look like a fresh edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_q1   <= 1'b1;
      sync_q2   <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync_q1   <= signal_in;
      sync_q2   <= sync_q1;
      line_prev <= sync_q2;
    end
  end

  assign rise      = sync_q2 & ~line_prev;
  assign fall      = ~sync_q2 & line_prev;
  assign line_edge = rise | fall;

  // cnt is cleared on every edge, so dur = cnt + 1 is the number of cycles
  // the line held its level up to the previous sample: on an edge cycle it
  // is the length of the level just ended.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)              cnt <= '0;
    else if (line_edge)      cnt <= '0;
    else if (cnt != '1)      cnt <= cnt + 32'd1;
  end

  assign dur     = {1'b0, cnt} + 33'd1;
  assign bit_ok0 = in_win(dur, BSD0_W);
  assign bit_ok1 = in_win(dur, BSD1_W);
  // A duration inside both windows (only possible with overlapping
  // parameters) decodes as 1.
  assign shift_next = {shift_q[MESSAGE_LENGTH-2:0], bit_ok1};

  always_comb begin
    limit    = '0;
    decoding = 1'b1;
    case (state)
      SYNC_BURST:   limit = SBD_W + MARGIN_W;
      SYNC_SILENCE: limit = SSD_W + MARGIN_W;
      BIT_BURST:    limit = BBD_W + MARGIN_W;
      BIT_SILENCE:  limit = BSIL_MAX;
      default:      decoding = 1'b0;
    endcase
  end

  // With no edge this cycle the level has now lasted dur+1 cycles; once that
  // exceeds the longest acceptable duration no later edge can be valid.
  assign timeout = decoding && !line_edge && (dur >= limit);

  always_comb begin
    abort = 1'b0;
    case (state)
      SYNC_BURST:   abort = fall && !in_win(dur, SBD_W);
      SYNC_SILENCE: abort = rise && !in_win(dur, SSD_W);
      BIT_BURST:    abort = fall && !in_win(dur, BBD_W);
      BIT_SILENCE:  abort = rise && !(bit_ok0 || bit_ok1);
      default:      abort = 1'b0;
    endcase
    abort = abort | timeout;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= WAIT_LOW;
      shift_q        <= '0;
      bit_cnt        <= '0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
      error_out      <= 1'b0;
      busy_out       <= 1'b0;
    end else begin
      data_valid_out <= 1'b0;
      error_out      <= 1'b0;
      if (abort) begin
        error_out <= 1'b1;
        busy_out  <= 1'b0;
        state     <= WAIT_LOW;
      end else begin
        case (state)
          WAIT_LOW: if (!sync_q2) state <= IDLE;
          IDLE: begin
            if (rise) begin
              state    <= SYNC_BURST;
              busy_out <= 1'b1;
              bit_cnt  <= '0;
              shift_q  <= '0;
            end
          end
          SYNC_BURST:   if (fall) state <= SYNC_SILENCE;
          SYNC_SILENCE: if (rise) state <= BIT_BURST;
          BIT_BURST:    if (fall) state <= BIT_SILENCE;
          BIT_SILENCE: begin
            if (rise) begin
              shift_q <= shift_next;
              if (bit_cnt == CW'(MESSAGE_LENGTH - 1)) begin
                data_out       <= shift_next;
                data_valid_out <= 1'b1;
                busy_out       <= 1'b0;
                state          <= STOP;
              end else begin
                bit_cnt <= bit_cnt + CW'(1);
                state   <= BIT_BURST;
              end
            end
          end
          // The stop pulse is ignored whatever its length.
          STOP:    if (!sync_q2) state <= IDLE;
          default: state <= WAIT_LOW;
        endcase
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_ir_receiver.sv
// Directed bench for ir_receiver with short durations so whole frames fit in
// a few hundred cycles. Inputs change on the falling clock edge; outputs are
// sampled on the falling edge.
module tb_ir_receiver;

  localparam int SBD  = 90;
  localparam int SSD  = 45;
  localparam int BBD  = 6;
  localparam int BSD0 = 6;
  localparam int BSD1 = 16;
  localparam int MRG  = 3;
  localparam int ML   = 8;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          signal_in;
  logic [ML-1:0] data_out;
  logic          data_valid_out;
  logic          error_out;
  logic          busy_out;
  logic [2:0]    state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;
  int val_cnt = 0;
  int err_cnt = 0;
  int v0, e0;
  logic [ML-1:0] exp_q[$];

  ir_receiver #(
    .SBD(SBD), .SSD(SSD), .BBD(BBD), .BSD0(BSD0), .BSD1(BSD1),
    .MARGIN(MRG), .MESSAGE_LENGTH(ML)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .signal_in(signal_in),
    .data_out(data_out),
    .data_valid_out(data_valid_out),
    .error_out(error_out),
    .busy_out(busy_out),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, required finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every valid pulse must match the oldest expected payload.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (data_valid_out) begin
        val_cnt++;
        if (exp_q.size() > 0) check("frame_data", 32'(data_out), 32'(exp_q.pop_front()));
        else                  check("spurious_valid", 32'(data_valid_out), 32'd0);
      end
      if (error_out) begin
        err_cnt++;
        if (data_valid_out) check("pulse_exclusive", 32'(error_out & data_valid_out), 32'd0);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic hold(input logic lvl, input int n);
    signal_in = lvl;
    repeat (n) @(negedge clk_in);
  endtask

  task automatic send_frame(input logic [ML-1:0] d);
    exp_q.push_back(d);
    hold(1'b1, SBD);
    check("busy_in_frame", 32'(busy_out), 32'd1);
    hold(1'b0, SSD);
    for (int i = ML - 1; i >= 0; i--) begin
      hold(1'b1, BBD);
      hold(1'b0, d[i] ? BSD1 : BSD0);
    end
    // Stop pulse: the valid strobe is registered on the 3rd rising edge
    // after the line goes high.
    signal_in = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    check("valid_early", 32'(data_valid_out), 32'd0);
    @(negedge clk_in);
    check("valid_latency", 32'(data_valid_out), 32'd1);
    hold(1'b1, BBD - 3);
    hold(1'b0, 20);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_in    = 1'b1;
    signal_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_valid", 32'(data_valid_out), 32'd0);
    check("rst_error", 32'(error_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // Reset released while the line is high: no spurious edge or error.
    rst_in = 1'b0;
    hold(1'b1, 10);
    hold(1'b0, 10);
    check("no_err_after_rst", 32'(err_cnt), 32'd0);

    // Single good frame.
    v0 = val_cnt; e0 = err_cnt;
    send_frame(8'hA5);
    check("a5_valid_cnt", 32'(val_cnt - v0), 32'd1);
    check("a5_err_cnt", 32'(err_cnt - e0), 32'd0);
    check("a5_data", 32'(data_out), 32'hA5);
    check("a5_busy_after", 32'(busy_out), 32'd0);

    // Back-to-back frames.
    v0 = val_cnt;
    send_frame(8'h00);
    check("b2b_first", 32'(data_out), 32'h00);
    send_frame(8'hFF);
    check("b2b_valid_cnt", 32'(val_cnt - v0), 32'd2);
    check("b2b_data", 32'(data_out), 32'hFF);

    // Sync burst of 80 cycles: outside 87..93, aborted at the falling edge.
    v0 = val_cnt; e0 = err_cnt;
    hold(1'b1, 80);
    signal_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    check("sync_err_early", 32'(error_out), 32'd0);
    @(negedge clk_in);
    check("sync_err_at_fall", 32'(error_out), 32'd1);
    hold(1'b0, 20);
    check("sync_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("sync_no_valid", 32'(val_cnt - v0), 32'd0);
    check("sync_data_held", 32'(data_out), 32'hFF);
    check("sync_busy", 32'(busy_out), 32'd0);

    // Bit silence of 11 cycles: between the 0 (3..9) and 1 (13..19) windows.
    e0 = err_cnt;
    hold(1'b1, SBD);
    hold(1'b0, SSD);
    hold(1'b1, BBD);
    hold(1'b0, 11);
    hold(1'b1, BBD);
    hold(1'b0, 20);
    check("gap_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("gap_state_idle", 32'(state_dbg), 32'd1);
    check("gap_data_held", 32'(data_out), 32'hFF);
    v0 = val_cnt;
    send_frame(8'h3C);
    check("gap_recover_cnt", 32'(val_cnt - v0), 32'd1);
    check("gap_recover_data", 32'(data_out), 32'h3C);

    // Line stuck low in BIT_SILENCE: after the line has been low for 20
    // synchronized cycles (longest valid silence is 19) the error is
    // registered; that is the 22nd falling clock edge after the drive.
    e0 = err_cnt;
    hold(1'b1, SBD);
    hold(1'b0, SSD);
    hold(1'b1, BBD);
    signal_in = 1'b0;
    repeat (21) @(negedge clk_in);
    check("timeout_early", 32'(error_out), 32'd0);
    @(negedge clk_in);
    check("timeout_cycle", 32'(error_out), 32'd1);
    hold(1'b0, 10);
    check("timeout_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("timeout_busy", 32'(busy_out), 32'd0);

    // Reset after 4 bits, during the 5th bit burst.
    v0 = val_cnt; e0 = err_cnt;
    hold(1'b1, SBD);
    hold(1'b0, SSD);
    for (int i = 0; i < 4; i++) begin
      hold(1'b1, BBD);
      hold(1'b0, (i % 2 == 0) ? BSD1 : BSD0);
    end
    signal_in = 1'b1;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    check("midrst_data", 32'(data_out), 32'd0);
    check("midrst_busy", 32'(busy_out), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'd0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    hold(1'b1, 5);
    hold(1'b0, 20);
    check("midrst_no_err", 32'(err_cnt - e0), 32'd0);
    check("midrst_no_valid", 32'(val_cnt - v0), 32'd0);
    send_frame(8'h5A);
    check("midrst_recover", 32'(data_out), 32'h5A);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
